// File: rtl/key_conditioner.sv
// key_conditioner
// ---------------------------------------------------------------------------
// Multi-channel push-button conditioner. Each raw button input is
// synchronised, debounced with its own stability counter, and decoded into:
// a debounced level, press/release pulses, a long-press pulse and an
// auto-repeat pulse train. Channels share nothing, so one bouncing button
// never disturbs the timing of another.
//
// Optional feature macro: KEY_CONDITIONER_REPEAT_EN
//   defined   -> per-channel repeat counter is built and btn_repeat pulses
//                every REPEAT_CYC cycles once btn_long has fired
//   undefined -> no repeat counter, btn_repeat is tied to 0
//
// Parameters:
//   CH          number of button channels (>=1)
//   SYNC        synchroniser flop stages (>=2)
//   STABLE_CYC  consecutive mismatch cycles before the level changes (>=2)
//   LONG_CYC    cycles the level must stay high before btn_long (>=1)
//   REPEAT_CYC  auto-repeat period after btn_long (>=1)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_in       raw asynchronous button inputs, 1 = pressed
//   btn_level    debounced level
//   btn_press    1-cycle pulse on the rising edge of btn_level
//   btn_release  1-cycle pulse on the falling edge of btn_level
//   btn_long     1-cycle pulse once the level has been high LONG_CYC cycles
//   btn_repeat   auto-repeat pulses after btn_long
// ---------------------------------------------------------------------------
module key_conditioner #(
  parameter int CH         = 5,
  parameter int SYNC       = 2,
  parameter int STABLE_CYC = 32768,
  parameter int LONG_CYC   = 3000000,
  parameter int REPEAT_CYC = 600000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn_in,
  output logic [CH-1:0] btn_level,
  output logic [CH-1:0] btn_press,
  output logic [CH-1:0] btn_release,
  output logic [CH-1:0] btn_long,
  output logic [CH-1:0] btn_repeat
);

  // The hold counter saturates at LONG_CYC itself, so it needs room for that
  // value, not just LONG_CYC-1.
  localparam int STABLE_W = $clog2(STABLE_CYC);
  localparam int HOLD_W   = $clog2(LONG_CYC + 1);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYC - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX    = HOLD_W'(LONG_CYC);

`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam int                REP_W    = $clog2(REPEAT_CYC + 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYC - 1);
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch

    logic [SYNC-1:0]     syncStages_q;
    logic [STABLE_W-1:0] stabCnt_q, stabCnt_d;
    logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                long_q, long_d;
    logic                syncedIn;
    logic                mismatch;
    logic                toggle;
    logic                holding;

    assign syncedIn = syncStages_q[SYNC-1];

    // Debounce and hold decode. "toggle" is the edge on which the level
    // flips; "holding" means the level is 1 now and stays 1 after this edge,
    // which is the only time the hold (and repeat) counters advance. A
    // falling toggle therefore clears them and suppresses long/repeat.
    always_comb begin
      mismatch  = syncedIn ^ level_q;
      toggle    = mismatch && (stabCnt_q == STABLE_LAST);
      holding   = level_q && !toggle;

      stabCnt_d = '0;
      if (mismatch && !toggle) begin
        stabCnt_d = stabCnt_q + 1'b1;
      end

      level_d   = level_q ^ toggle;
      press_d   = toggle && !level_q;
      release_d = toggle && level_q;

      holdCnt_d = '0;
      long_d    = 1'b0;
      if (holding) begin
        holdCnt_d = (holdCnt_q == HOLD_MAX) ? holdCnt_q : holdCnt_q + 1'b1;
        long_d    = (holdCnt_q == HOLD_LAST);
      end
    end

    // Synchroniser and per-channel state registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        syncStages_q <= '0;
        stabCnt_q    <= '0;
        holdCnt_q    <= '0;
        level_q      <= 1'b0;
        press_q      <= 1'b0;
        release_q    <= 1'b0;
        long_q       <= 1'b0;
      end else begin
        syncStages_q <= {syncStages_q[SYNC-2:0], btn_in[i]};
        stabCnt_q    <= stabCnt_d;
        holdCnt_q    <= holdCnt_d;
        level_q      <= level_d;
        press_q      <= press_d;
        release_q    <= release_d;
        long_q       <= long_d;
      end
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    logic [REP_W-1:0] repCnt_q, repCnt_d;
    logic             repeat_q, repeat_d;
    logic             repActive;

    // The repeat counter only runs once the hold counter has saturated
    // (btn_long already fired) and the level is staying high; it wraps and
    // pulses every REPEAT_CYC cycles.
    always_comb begin
      repActive = holding && (holdCnt_q == HOLD_MAX);
      repCnt_d  = '0;
      repeat_d  = 1'b0;
      if (repActive) begin
        if (repCnt_q == REP_LAST) begin
          repeat_d = 1'b1;
        end else begin
          repCnt_d = repCnt_q + 1'b1;
        end
      end
    end

    // Repeat state registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        repCnt_q <= '0;
        repeat_q <= 1'b0;
      end else begin
        repCnt_q <= repCnt_d;
        repeat_q <= repeat_d;
      end
    end

    assign btn_repeat[i] = repeat_q;
`else
    assign btn_repeat[i] = 1'b0;
`endif

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule
